tdm_mux81: RTL and testbench
============================

# tdm_mux81

Round-robin 8-to-1 collector that merges eight requesting source channels onto one registered output with a valid/ready handshake. It is the gathering counterpart of our 1-to-8 demultiplexer: where that block steers one input onto one of eight outputs by select, this block chooses one of eight inputs, reports the chosen index on `s`, and returns a one-hot `ack` to the source it served. It sits between eight producers and a single downstream consumer.

## Interface

- `WIDTH`, default 8: data bits per channel.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: block enable; low forces outputs idle.
- `d`  in  8*WIDTH: channel data; channel i is `d[i*WIDTH +: WIDTH]`.
- `req`  in  8: per-channel request; channel i holds `req[i]` and its data stable until it sees `ack[i]`.
- `ready`  in  1: downstream accepts `y` when `valid & ready`.
- `y`  out  WIDTH: registered selected data.
- `s`  out  3: registered index of the channel held in `y`.
- `valid`  out  1: `y`/`s` hold an unconsumed word.
- `ack`  out  8: one-hot grant, high for exactly one cycle per captured word.

## Operation

- Reset (async, `rst_n`=0): `y`=0, `s`=0, `valid`=0, `ack`=0, internal pointer `ptr`=0, state EMPTY.
- State: EMPTY (`valid`=0) and FULL (`valid`=1).
- Capture condition `load` = `en` & (EMPTY | `ready`) & any eligible request.
- Eligible request: `req[i]`=1 and `ack[i]`=0 in the current cycle. Masking the channel acked this cycle prevents double-grant while its `req` is still high.
- Arbitration: search channels `ptr`, `ptr`+1, … modulo 8, and take the first eligible one as `ch`. 3-bit wrap, so 7 is followed by 0.
- On `load`: `y`←`d[ch]`, `s`←`ch`, `valid`←1, `ack`←one-hot(`ch`), `ptr`←`ch`+1 mod 8, state FULL.
- FULL with `ready`=1 and no eligible request: `valid`←0, state EMPTY. `y` and `s` keep their last values, and `ack`←0.
- FULL with `ready`=0: `y`, `s`, `valid`, and `ptr` hold, and `ack`←0. No new grant is made under backpressure.
- EMPTY with no eligible request: everything holds, and `ack`←0.
- `en`=0 (sampled at edge): `valid`←0, `y`←0, `ack`←0, state EMPTY. `s` and `ptr` hold. A word in FULL is discarded and is not re-offered. Channels are never acked for discarded words beyond the original ack.
- `ack` is never high for more than one cycle consecutively on the same bit.
- `ack` is all-zero in any cycle where `valid` did not just load.

## Timing

- Latency: requests and data sampled at edge N appear on `y`/`s`/`valid`/`ack` after edge N. This is one cycle of registered latency.
- Throughput: one word per cycle when `ready` is held high and eligible requests exist, with back-to-back grants.
- A source whose `req` stays high after `ack` is re-granted no earlier than the second cycle after its ack. With all eight requesting, it is re-granted after the other seven.
- Handshake: transfer occurs at any edge where `valid`=1 and `ready`=1. The same edge may load the next word.
- Simultaneous `ready`=1 and new eligible request in FULL: the old word is consumed and the new word is loaded at the same edge, so `valid` stays 1.
- Reset assertion mid-transfer clears immediately, without waiting for `clk`. Deassertion is synchronous to the first following edge. Drivers release `rst_n` away from the rising edge.

## Test plan

- Reset: assert `rst_n`=0 with `req`=8'hFF → `y`=0, `s`=0, `valid`=0, `ack`=0. After release with `en`=0, outputs stay 0.
- Single channel: `en`=1, `ready`=1, `req`=8'b0010_0000, `d[5]`=8'hA5 → next cycle `y`=8'hA5, `s`=5, `valid`=1, `ack`=8'h20. Drop `req` → following cycle `valid`=0, `ack`=0.
- Round-robin wrap: `req`=8'hFF held, `ready`=1, `d[i]`=i → `s` sequence 0,1,…,7,0. The `ack` bits follow one-hot. `valid` stays continuously 1.
- Backpressure: load channel 3 (`y`=8'h33), then `ready`=0 for 4 cycles with `req`=8'hFF → `y`=8'h33, `s`=3, `valid`=1, `ack`=0 throughout. Raise `ready` → next `s`=4.
- Enable drop: FULL with `s`=6, drive `en`=0 → next cycle `valid`=0, `y`=0, `ack`=0. Re-enable with `req`=8'hFF → next grant is `s`=7.
- Reset mid-operation: during the `req`=8'hFF stream at `s`=4, pulse `rst_n` low between edges → outputs zero immediately. After release, the first grant is `s`=0.

Source files
------------

// File: rtl/tdm_mux81_if.sv
// ---------------------------------------------------------------------------
// tdm_mux81_if
// Bundle of the data/handshake signals between eight producers (plus the
// downstream ready) and the tdm_mux81 collector.
//   en    : block enable
//   d     : 8 x WIDTH channel data, channel i at d[i*WIDTH +: WIDTH]
//   req   : per-channel request, held with data until the matching ack
//   ready : downstream accepts y when valid & ready
//   y     : registered selected data
//   s     : index of the channel held in y
//   valid : y/s hold an unconsumed word
//   ack   : one-hot, one-cycle grant to the served channel
// Modports: master drives the inputs of the collector, slave is the collector.
// ---------------------------------------------------------------------------
interface tdm_mux81_if #(
  parameter int WIDTH = 8
);
  logic               en;
  logic [8*WIDTH-1:0] d;
  logic [7:0]         req;
  logic               ready;
  logic [WIDTH-1:0]   y;
  logic [2:0]         s;
  logic               valid;
  logic [7:0]         ack;

  modport master (
    output en, d, req, ready,
    input  y, s, valid, ack
  );

  modport slave (
    input  en, d, req, ready,
    output y, s, valid, ack
  );
endinterface

// File: rtl/tdm_mux81.sv
// ---------------------------------------------------------------------------
// tdm_mux81
// Round-robin 8-to-1 collector. Picks the first eligible requester starting
// at an internal pointer, registers its data on y and its index on s, and
// returns a one-cycle one-hot ack to that channel. Output uses valid/ready.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tdm_mux81_if.slave (en, d, req, ready in; y, s, valid, ack out)
// ---------------------------------------------------------------------------
module tdm_mux81 #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_mux81_if.slave     bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [2:0]       s_reg, s_next;
  logic [7:0]       ack_reg, ack_next;

  logic [WIDTH-1:0] d_ch [8];
  logic [7:0]       elig;
  logic [2:0]       cand_idx [8];
  logic [7:0]       rot_elig;
  logic [2:0]       offset;
  logic             found;
  logic [2:0]       ch;
  logic             load;

  // The channel acked this cycle still has req high; masking it stops a
  // second grant for the same word.
  assign elig = bus.req & ~ack_reg;

  // Rotate the eligibility vector so that bit 0 is the channel at ptr; the
  // 3-bit add wraps 7 back to 0.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_chan
      assign d_ch[gi]     = bus.d[gi*WIDTH +: WIDTH];
      assign cand_idx[gi] = ptr_reg + 3'(gi);
      assign rot_elig[gi] = elig[cand_idx[gi]];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the nearest requester after ptr.
  always_comb begin
    found  = 1'b0;
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_elig[k]) begin
        found  = 1'b1;
        offset = 3'(k);
      end
    end
  end

  assign ch   = ptr_reg + offset;
  assign load = bus.en & ((state_reg == EMPTY) | bus.ready) & found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      ptr_reg   <= 3'd0;
      y_reg     <= '0;
      s_reg     <= 3'd0;
      ack_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      y_reg     <= y_next;
      s_reg     <= s_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    y_next     = y_reg;
    s_next     = s_reg;
    ack_next   = 8'd0;

    if (!bus.en) begin
      // Any held word is dropped; s and ptr keep their values so the
      // rotation resumes where it left off.
      state_next = EMPTY;
      y_next     = '0;
    end else if (load) begin
      // Covers both a fresh load and consume-plus-reload in the same edge.
      state_next = FULL;
      y_next     = d_ch[ch];
      s_next     = ch;
      ack_next   = 8'd1 << ch;
      ptr_next   = ch + 3'd1;
    end else if ((state_reg == FULL) && bus.ready) begin
      state_next = EMPTY;
    end
  end

  assign bus.y     = y_reg;
  assign bus.s     = s_reg;
  assign bus.valid = (state_reg == FULL);
  assign bus.ack   = ack_reg;

endmodule

// File: tb/tb_tdm_mux81.sv
// ---------------------------------------------------------------------------
// tb_tdm_mux81
// Directed scenarios for tdm_mux81. Each scenario pushes the expected
// (y, s, valid, ack) after the next edge into a scoreboard queue, then pops
// and compares it once the DUT outputs have settled.
// ---------------------------------------------------------------------------
module tb_tdm_mux81;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  tdm_mux81_if #(.WIDTH(WIDTH)) bus ();

  tdm_mux81 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [2:0] s;
    logic       valid;
    logic [7:0] ack;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_exp(input string name, input logic [7:0] y,
                          input logic [2:0] s, input logic valid,
                          input logic [7:0] ack);
    exp_t x;
    x.name = name; x.y = y; x.s = s; x.valid = valid; x.ack = ack;
    sb.push_back(x);
  endtask

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d_pattern();
    for (int i = 0; i < 8; i++) bus.d[i*WIDTH +: WIDTH] = 8'(8'h11 * i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.en = 1'b1; bus.ready = 1'b1; bus.req = 8'hFF; bus.d = '0;
    #1 rst_n = 1'b0;
    #1;
    push_exp("reset_async", 8'h00, 3'd0, 1'b0, 8'h00);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      if (c == 1) push_exp("reset_held", 8'h00, 3'd0, 1'b0, 8'h00);
      if (c == 2) begin
        push_exp("reset_held", 8'h00, 3'd0, 1'b0, 8'h00);
        rst_n = 1'b1;
        bus.en = 1'b0;
      end
      if (c >= 3) push_exp("reset_release_en0", 8'h00, 3'd0, 1'b0, 8'h00);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.s, bus.valid, bus.ack} !== {e.y, e.s, e.valid, e.ack}) begin
          n_err++;
          $display("FAIL %s: y=%h s=%0d valid=%b ack=%h, expected y=%h s=%0d valid=%b ack=%h",
                   e.name, bus.y, bus.s, bus.valid, bus.ack, e.y, e.s, e.valid, e.ack);
        end else
          $display("ok   %s: y=%h s=%0d valid=%b ack=%h", e.name, bus.y, bus.s, bus.valid, bus.ack);
      end
    end
  endtask

  task automatic test_single();
    bus.en = 1'b1; bus.ready = 1'b1; bus.d = '0;
    bus.d[5*WIDTH +: WIDTH] = 8'hA5;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        bus.req = 8'b0010_0000;
        push_exp("single_load", 8'hA5, 3'd5, 1'b1, 8'h20);
      end else begin
        bus.req = 8'h00;
        push_exp("single_drain", 8'hA5, 3'd5, 1'b0, 8'h00);
      end
      tick();
      while (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.s, bus.valid, bus.ack} !== {e.y, e.s, e.valid, e.ack}) begin
          n_err++;
          $display("FAIL %s: y=%h s=%0d valid=%b ack=%h, expected y=%h s=%0d valid=%b ack=%h",
                   e.name, bus.y, bus.s, bus.valid, bus.ack, e.y, e.s, e.valid, e.ack);
        end else
          $display("ok   %s: y=%h s=%0d valid=%b ack=%h", e.name, bus.y, bus.s, bus.valid, bus.ack);
      end
    end
  endtask

  // A lone channel holding req is masked the cycle after its ack and is
  // granted again one cycle later.
  task automatic test_back_to_back();
    bus.en = 1'b1; bus.ready = 1'b1; bus.d = '0;
    bus.d[2*WIDTH +: WIDTH] = 8'h5A;
    bus.req = 8'b0000_0100;
    push_exp("rearm_grant", 8'h5A, 3'd2, 1'b1, 8'h04);
    push_exp("rearm_masked", 8'h5A, 3'd2, 1'b0, 8'h00);
    push_exp("rearm_regrant", 8'h5A, 3'd2, 1'b1, 8'h04);
    for (int c = 0; c < 3; c++) begin
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({bus.y, bus.s, bus.valid, bus.ack} !== {e.y, e.s, e.valid, e.ack}) begin
        n_err++;
        $display("FAIL %s: y=%h s=%0d valid=%b ack=%h, expected y=%h s=%0d valid=%b ack=%h",
                 e.name, bus.y, bus.s, bus.valid, bus.ack, e.y, e.s, e.valid, e.ack);
      end else
        $display("ok   %s: y=%h s=%0d valid=%b ack=%h", e.name, bus.y, bus.s, bus.valid, bus.ack);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.en = 1'b1; bus.ready = 1'b1;
    set_d_pattern();
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      push_exp("wrap", 8'(8'h11 * (k % 8)), 3'(k % 8), 1'b1, 8'(8'd1 << (k % 8)));
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({bus.y, bus.s, bus.valid, bus.ack} !== {e.y, e.s, e.valid, e.ack}) begin
        n_err++;
        $display("FAIL %s[%0d]: y=%h s=%0d valid=%b ack=%h, expected y=%h s=%0d valid=%b ack=%h",
                 e.name, k, bus.y, bus.s, bus.valid, bus.ack, e.y, e.s, e.valid, e.ack);
      end else
        $display("ok   %s[%0d]: y=%h s=%0d valid=%b ack=%h", e.name, k, bus.y, bus.s, bus.valid, bus.ack);
    end
  endtask

  // Loads channel 3, holds under backpressure, resumes at 4; then loads 6,
  // drops enable, and resumes at 7 then 0.
  task automatic test_backpressure_enable();
    do_reset();
    bus.en = 1'b1; bus.ready = 1'b1;
    set_d_pattern();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin bus.req = 8'h08; push_exp("bp_load3", 8'h33, 3'd3, 1'b1, 8'h08); end
        1, 2, 3, 4: begin
          bus.req = 8'hFF; bus.ready = 1'b0;
          push_exp("bp_hold", 8'h33, 3'd3, 1'b1, 8'h00);
        end
        5: begin bus.ready = 1'b1; push_exp("bp_resume4", 8'h44, 3'd4, 1'b1, 8'h10); end
        6: begin bus.req = 8'h40; push_exp("en_load6", 8'h66, 3'd6, 1'b1, 8'h40); end
        7: begin bus.en = 1'b0; push_exp("en_drop", 8'h00, 3'd6, 1'b0, 8'h00); end
        8: begin bus.en = 1'b1; bus.req = 8'hFF; push_exp("en_resume7", 8'h77, 3'd7, 1'b1, 8'h80); end
        default: push_exp("en_wrap0", 8'h00, 3'd0, 1'b1, 8'h01);
      endcase
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({bus.y, bus.s, bus.valid, bus.ack} !== {e.y, e.s, e.valid, e.ack}) begin
        n_err++;
        $display("FAIL %s: y=%h s=%0d valid=%b ack=%h, expected y=%h s=%0d valid=%b ack=%h",
                 e.name, bus.y, bus.s, bus.valid, bus.ack, e.y, e.s, e.valid, e.ack);
      end else
        $display("ok   %s: y=%h s=%0d valid=%b ack=%h", e.name, bus.y, bus.s, bus.valid, bus.ack);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.en = 1'b1; bus.ready = 1'b1; bus.req = 8'hFF;
    set_d_pattern();
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        push_exp("mid_stream", 8'(8'h11 * c), 3'(c), 1'b1, 8'(8'd1 << c));
        tick();
      end else if (c == 5) begin
        // Asynchronous clear between edges, checked before any clock edge.
        rst_n = 1'b0;
        #1;
        push_exp("mid_async_clear", 8'h00, 3'd0, 1'b0, 8'h00);
      end else begin
        rst_n = 1'b1;
        push_exp("mid_first_grant", 8'h00, 3'd0, 1'b1, 8'h01);
        tick();
      end
      e = sb.pop_front();
      n_cmp++;
      if ({bus.y, bus.s, bus.valid, bus.ack} !== {e.y, e.s, e.valid, e.ack}) begin
        n_err++;
        $display("FAIL %s: y=%h s=%0d valid=%b ack=%h, expected y=%h s=%0d valid=%b ack=%h",
                 e.name, bus.y, bus.s, bus.valid, bus.ack, e.y, e.s, e.valid, e.ack);
      end else
        $display("ok   %s: y=%h s=%0d valid=%b ack=%h", e.name, bus.y, bus.s, bus.valid, bus.ack);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_backpressure_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
